// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - word-serial wide add/subtract over one shared 32-bit adder

module carry_increment_adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o,
    output logic        of_o
);
    logic [3:0][8:0] blk_raw;
    logic [3:0][7:0] blk_sum;
    logic [4:0]      carry;

    // Four 8-bit blocks add without carry-in, then each is incremented by the rippled block carry.
    always_comb begin
        blk_raw  = '0;
        blk_sum  = '0;
        carry    = '0;
        carry[0] = cin_i;
        for (int k = 0; k < 4; k++) begin
            blk_raw[k]   = {1'b0, a_i[k*8 +: 8]} + {1'b0, b_i[k*8 +: 8]};
            blk_sum[k]   = blk_raw[k][7:0] + {7'b0, carry[k]};
            carry[k+1]   = blk_raw[k][8] | ((&blk_raw[k][7:0]) & carry[k]);
        end
    end

    assign sum_o  = blk_sum;
    assign cout_o = carry[4];
    assign of_o   = (a_i[31] == b_i[31]) && (sum_o[31] != a_i[31]);
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4,
    parameter int W     = 32 * WORDS
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         sub_i,
    input  logic         cin_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         of_o
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q;
    logic [WORDS-1:0][31:0]     a_q;
    logic [WORDS-1:0][31:0]     b_q;
    logic [WORDS-1:0][31:0]     s_w_q;
    logic [WORDS-1:0][31:0]     s_w_d;
    logic                       c_q;
    logic [IDXW-1:0]            idx_q;
    logic                       busy_q;
    logic                       done_q;
    logic [W-1:0]               sum_q;
    logic                       cout_q;
    logic                       of_q;

    logic [31:0]                add_sum;
    logic                       add_cout;
    logic                       add_of;

    carry_increment_adder32 u_adder (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (c_q),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .of_o   (add_of)
    );

    // Merge the current word's adder result into the working register.
    always_comb begin
        s_w_d        = s_w_q;
        s_w_d[idx_q] = add_sum;
    end

    // Sequencer: capture operands on start, step one word per cycle, publish the result on the last word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_w_q   <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        c_q     <= sub_i | cin_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    s_w_q <= s_w_d;
                    c_q   <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= s_w_d;
                        cout_q  <= add_cout;
                        of_q    <= add_of;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign of_o   = of_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - directed self-checking bench for multiword_add_seq

module tb_multiword_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         of;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_of;

    always #5 clk = ~clk;

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .sub_i   (sub),
        .cin_i   (cin),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout),
        .of_o    (of)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation from an idle start; inputs are scrambled after capture to show they are ignored.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            start = 1'b0; a = ~ta; b = ~tb_v; sub = ~ts; cin = ~tc;
            check({tag, "_busy"}, busy, 1);
            check({tag, "_nodone"}, done, 0);
            check({tag, "_sum_held"}, sum, last_sum);
            check({tag, "_cout_held"}, cout, last_cout);
            check({tag, "_of_held"}, of, last_of);
        end
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_of"}, of, eo);
        last_sum = es; last_cout = ec; last_of = eo;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        last_sum = '0; last_cout = 1'b0; last_of = 1'b0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_of", of, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("ripple", {W{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        run_op("pos_of", {1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0,
               {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        run_op("sub_borrow", 128'd0, 128'd1, 1'b1, 1'b1, {W{1'b1}}, 1'b0, 1'b0);
        run_op("sub_of", {1'b1, {(W-1){1'b0}}}, 128'd1, 1'b1, 1'b0,
               {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1);

        // Start held high through RUN with moving operands, then a back-to-back op from DONE.
        @(negedge clk);
        a = 128'd5; b = 128'd7; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            a = 128'h1000 + 128'(i); b = 128'h2000 - 128'(i);
            check("hold_busy", busy, 1);
            check("hold_sum_held", sum, last_sum);
        end
        a = 128'hAF; b = 128'hAF; cin = 1'b1; sub = 1'b0;
        @(negedge clk);
        check("hold_done", done, 1);
        check("hold_sum", sum, 128'hC);
        check("hold_cout", cout, 0);
        check("hold_of", of, 0);
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        check("b2b_busy_no_gap", busy, 1);
        check("b2b_done_low", done, 0);
        for (int i = 1; i < WORDS; i++) begin
            @(negedge clk);
            check("b2b_busy", busy, 1);
        end
        @(negedge clk);
        check("b2b_done", done, 1);
        check("b2b_sum", sum, 128'h15F);
        check("b2b_cout", cout, 0);
        check("b2b_of", of, 0);
        @(negedge clk);
        check("b2b_no_extra_op", busy, 0);
        check("b2b_done_pulse", done, 0);

        // Reset two cycles into RUN; outputs must clear before any further clock edge.
        @(negedge clk);
        a = 128'd1; b = 128'd1; start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        check("arst_of", of, 0);
        last_sum = '0; last_cout = 1'b0; last_of = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 128'h123, {{116{1'b1}}, 12'h123}, 1'b0, 1'b0,
               {{116{1'b1}}, 12'h246}, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that performs a WORDS×32-bit add or subtract by time-multiplexing one 32-bit `CarryIncrementAdder` instance. It handles one 32-bit word per cycle, least-significant word first, and registers the carry between words. It sits between a wide-operand requester and the single shared 32-bit adder datapath, and returns the full-width sum, carry-out and signed overflow through a start/done handshake.

## Interface
- WORDS, 4, number of 32-bit words per operand (≥1); full width W = 32·WORDS
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE or DONE
- sub  in  1  0: a+b+cin; 1: a+~b+1 (cin ignored); captured with start
- cin  in  1  carry-in for add mode; captured with start
- a  in  W  operand A; captured with start
- b  in  W  operand B; captured with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result valid
- sum  out  W  result; held from done until the next result is loaded
- cout  out  1  carry out of bit W-1 (add); no-borrow flag (sub)
- of  out  1  signed overflow of the full W-bit operation

## Operation
- Internal state:
  - operand registers A_r and B_r (B_r already inverted when sub=1)
  - carry register c_r
  - word index idx, width max(1, clog2(WORDS))
  - working register S_w
  - result registers sum, cout, of
- FSM has states IDLE, RUN and DONE.
- IDLE:
  - start=1 → load A_r, B_r, c_r (cin in add mode, 1 in sub mode) and idx=0, then go to RUN.
  - start=0 → remain in IDLE.
- RUN:
  - Each cycle the adder receives A_r word idx, B_r word idx and c_r.
  - The adder sum is written to S_w word idx, and the adder Cout is written to c_r.
  - idx<WORDS-1 → idx+1 and stay in RUN.
  - idx=WORDS-1 → load sum={adder sum, lower words of S_w}, cout=adder Cout, of=adder of (MS word), then go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 → capture new operands as in IDLE and go to RUN (back-to-back operation).
  - start=0 → go to IDLE.
- start during RUN is ignored and not queued.
- Changes on a, b, sub and cin after capture have no effect on the operation in flight.
- The adder's of output is used only on the most-significant word. The of outputs from lower words are discarded.
- WORDS=1: RUN lasts one cycle.

## Timing
- Reset values (asserted asynchronously): state=IDLE, busy=0, done=0, sum=0, cout=0, of=0, idx=0, c_r=0, A_r=0, B_r=0, S_w=0.
- Reset mid-RUN aborts the operation. Outputs take their reset values immediately, and the first start after rst_n deasserts is served normally.
- Latency: if start is sampled at edge E0, then:
  - busy=1 from E0 to E_WORDS;
  - done=1 from E_WORDS to E_(WORDS+1);
  - sum, cout and of update at E_WORDS.
- Throughput: one operation per WORDS+1 cycles.
- sum, cout and of keep their previous values throughout RUN.
- busy and done are never high in the same cycle.
- Arithmetic:
  - The result is exact modulo 2^W.
  - In add mode cout is the carry out of bit W-1.
  - In sub mode, cout=1 iff a ≥ b (unsigned).
  - of=1 iff the operands entering the MS word stage (a and b, or a and ~b) have equal sign bits and sum[W-1] differs from them.

## Test plan (WORDS=4, W=128)
- Full carry ripple: a=all ones, b=1, cin=0, sub=0 → sum=0, cout=1, of=0; done exactly 4 cycles after the start edge; busy high 4 cycles.
- Positive overflow: a=0x7FFF…FFFF, b=1, cin=0 → sum=0x8000…0000, cout=0, of=1.
- Subtract with borrow and a cin check:
  - First: a=0, b=1, sub=1, cin=1 → sum=all ones, cout=0, of=0.
  - Second: a=0x8000…0000, b=1, sub=1 → sum=0x7FFF…FFFF, cout=1, of=1.
- Handshake:
  - Hold start high and toggle a and b during RUN → the in-flight result is unchanged and there is no extra op.
  - start=1 in the DONE cycle with a=0xAF, b=0xAF, cin=1 → next op begins with no IDLE gap and gives sum=0x15F, cout=0, of=0.
- Reset mid-operation: drop rst_n two cycles into RUN → busy, done, sum, cout and of are 0 without waiting for a clock edge. Then release reset and start a=0x123, b=0xFFFF…FFF123 (sign-extended) → sum=0xFFFF…FFF246, cout=0, of=0.
